// File: rtl/mc_control.sv
// mc_control: multi-cycle control sequencer for the single-ALU MIPS datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives
// the datapath mux selects, write enables and the 2-bit alu_op.
//
// Optional feature macro: MC_ADDI_EN (adds addi via ADDIEX -> ADDIWB).
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   opcode[5:0]       : IR[31:26]
//   mem_ready         : memory finished current access this cycle
//   pc_write,
//   pc_write_cond     : PC load enable / PC load if ALU zero
//   i_or_d            : address select (0 PC, 1 ALUOut)
//   mem_read,
//   mem_write         : memory strobes
//   ir_write          : IR load enable
//   mem_to_reg        : write-data select (1 MDR)
//   reg_dst           : destination select (1 rd, 0 rt)
//   reg_write         : register-file write enable
//   alu_src_a         : 0 PC, 1 A
//   alu_src_b[1:0]    : 00 B, 01 4, 10 imm, 11 imm<<2
//   alu_op[1:0]       : 00 add, 01 sub, 10 funct
//   pc_source[1:0]    : 00 ALU, 01 ALUOut, 10 jump target
//   instr_done        : pulse in an instruction's final state
//   illegal_op        : pulse on an undecodable opcode
//   state[3:0]        : current state (debug)
module mc_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    state_e state_q, state_d;

    // Ungated Moore decode; forced to zero below while rst is high.
    logic       pc_write_s;
    logic       pc_write_cond_s;
    logic       i_or_d_s;
    logic       mem_read_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       mem_to_reg_s;
    logic       reg_dst_s;
    logic       reg_write_s;
    logic       alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] alu_op_s;
    logic [1:0] pc_source_s;
    logic       instr_done_s;
    logic       illegal_op_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        unique case (state_q)
            S_FETCH: begin
                state_d = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE: state_d = S_EXEC;
                    OP_LW:    state_d = S_MEMADR;
                    OP_SW:    state_d = S_MEMADR;
                    OP_BEQ:   state_d = S_BRANCH;
                    OP_J:     state_d = S_JUMP;
`ifdef MC_ADDI_EN
                    OP_ADDI:  state_d = S_ADDIEX;
`endif
                    default:  state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                // Opcode is held stable; anything else falls back to FETCH.
                if (opcode == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (opcode == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD: begin
                state_d = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWR: begin
                state_d = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                state_d = S_ALUWB;
            end
`ifdef MC_ADDI_EN
            S_ADDIEX: begin
                state_d = S_ADDIWB;
            end
`endif
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_comb begin
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        i_or_d_s        = 1'b0;
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        ir_write_s      = 1'b0;
        mem_to_reg_s    = 1'b0;
        reg_dst_s       = 1'b0;
        reg_write_s     = 1'b0;
        alu_src_a_s     = 1'b0;
        alu_src_b_s     = 2'b00;
        alu_op_s        = 2'b00;
        pc_source_s     = 2'b00;
        instr_done_s    = 1'b0;
        illegal_op_s    = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_read_s  = 1'b1;
                alu_src_b_s = 2'b01;
                // IR and PC only load on the cycle the fetch completes.
                ir_write_s  = mem_ready;
                pc_write_s  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b_s = 2'b11;
                case (opcode)
                    OP_RTYPE,
                    OP_LW,
                    OP_SW,
                    OP_BEQ,
`ifdef MC_ADDI_EN
                    OP_ADDI,
`endif
                    OP_J:    illegal_op_s = 1'b0;
                    default: illegal_op_s = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
            end
            S_MEMRD: begin
                mem_read_s = 1'b1;
                i_or_d_s   = 1'b1;
            end
            S_MEMWB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
                instr_done_s = 1'b1;
            end
            S_MEMWR: begin
                mem_write_s  = 1'b1;
                i_or_d_s     = 1'b1;
                instr_done_s = mem_ready;
            end
            S_EXEC: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = 2'b10;
            end
            S_ALUWB: begin
                reg_write_s  = 1'b1;
                reg_dst_s    = 1'b1;
                instr_done_s = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_s     = 1'b1;
                alu_op_s        = 2'b01;
                pc_write_cond_s = 1'b1;
                pc_source_s     = 2'b01;
                instr_done_s    = 1'b1;
            end
            S_JUMP: begin
                pc_write_s   = 1'b1;
                pc_source_s  = 2'b10;
                instr_done_s = 1'b1;
            end
`ifdef MC_ADDI_EN
            S_ADDIEX: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
            end
            S_ADDIWB: begin
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
`endif
            default: begin
                pc_write_s = 1'b0;
            end
        endcase
    end

    // Reset blanks everything immediately, so an abandoned instruction
    // issues no further strobes in the reset cycle.
    always_comb begin
        pc_write      = pc_write_s      & ~rst;
        pc_write_cond = pc_write_cond_s & ~rst;
        i_or_d        = i_or_d_s        & ~rst;
        mem_read      = mem_read_s      & ~rst;
        mem_write     = mem_write_s     & ~rst;
        ir_write      = ir_write_s      & ~rst;
        mem_to_reg    = mem_to_reg_s    & ~rst;
        reg_dst       = reg_dst_s       & ~rst;
        reg_write     = reg_write_s     & ~rst;
        alu_src_a     = alu_src_a_s     & ~rst;
        alu_src_b     = alu_src_b_s     & {2{~rst}};
        alu_op        = alu_op_s        & {2{~rst}};
        pc_source     = pc_source_s     & {2{~rst}};
        instr_done    = instr_done_s    & ~rst;
        illegal_op    = illegal_op_s    & ~rst;
        state         = state_q         & {4{~rst}};
    end

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed self-checking bench for mc_control.
// Hand-built expected output vectors per cycle, sampled at negedge.
module tb_mc_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
    logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       instr_done, illegal_op;
    logic [3:0] state;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mc_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
        .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
    );

    localparam logic [17:0] PCW    = 18'h1 << 17;
    localparam logic [17:0] PWC    = 18'h1 << 16;
    localparam logic [17:0] IOD    = 18'h1 << 15;
    localparam logic [17:0] MRD    = 18'h1 << 14;
    localparam logic [17:0] MWR    = 18'h1 << 13;
    localparam logic [17:0] IRW    = 18'h1 << 12;
    localparam logic [17:0] M2R    = 18'h1 << 11;
    localparam logic [17:0] RDST   = 18'h1 << 10;
    localparam logic [17:0] RWR    = 18'h1 << 9;
    localparam logic [17:0] SA     = 18'h1 << 8;
    localparam logic [17:0] SB_4   = 18'h1 << 6;
    localparam logic [17:0] SB_IMM = 18'h2 << 6;
    localparam logic [17:0] SB_SH  = 18'h3 << 6;
    localparam logic [17:0] AO_SUB = 18'h1 << 4;
    localparam logic [17:0] AO_FN  = 18'h2 << 4;
    localparam logic [17:0] PS_OUT = 18'h1 << 2;
    localparam logic [17:0] PS_J   = 18'h2 << 2;
    localparam logic [17:0] DONE   = 18'h1 << 1;
    localparam logic [17:0] ILL    = 18'h1;

    localparam logic [17:0] V_FETCH  = PCW | MRD | IRW | SB_4;
    localparam logic [17:0] V_FSTALL = MRD | SB_4;
    localparam logic [17:0] V_DEC    = SB_SH;
    localparam logic [17:0] V_DECILL = SB_SH | ILL;
    localparam logic [17:0] V_MADR   = SA | SB_IMM;
    localparam logic [17:0] V_MRD    = MRD | IOD;
    localparam logic [17:0] V_MWB    = RWR | M2R | DONE;
    localparam logic [17:0] V_MWR    = MWR | IOD;
    localparam logic [17:0] V_MWRD   = MWR | IOD | DONE;
    localparam logic [17:0] V_EXEC   = SA | AO_FN;
    localparam logic [17:0] V_ALUWB  = RWR | RDST | DONE;
    localparam logic [17:0] V_BR     = SA | AO_SUB | PWC | PS_OUT | DONE;
    localparam logic [17:0] V_JMP    = PCW | PS_J | DONE;
    localparam logic [17:0] V_AIEX   = SA | SB_IMM;
    localparam logic [17:0] V_AIWB   = RWR | DONE;

    function automatic logic [17:0] outs();
        return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                alu_src_b, alu_op, pc_source, instr_done, illegal_op};
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Drive one cycle's inputs at negedge, then check that cycle.
    task automatic cyc(input string tag, input logic r, input logic mr,
                       input logic [5:0] op, input logic [3:0] es,
                       input logic [17:0] ev);
        @(negedge clk);
        rst = r;
        mem_ready = mr;
        opcode = op;
        #1;
        check({tag, ".state"}, {28'd0, state}, {28'd0, es});
        check({tag, ".outs"}, {14'd0, outs()}, {14'd0, ev});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: sim time exceeded");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        mem_ready = 1'b1;
        opcode = 6'h00;

        cyc("rst0", 1, 1, 6'h00, 4'd0, 18'h0);
        cyc("rst1", 1, 1, 6'h00, 4'd0, 18'h0);

        cyc("r.fetch", 0, 1, 6'h00, 4'd0, V_FETCH);
        cyc("r.dec",   0, 0, 6'h00, 4'd1, V_DEC);
        cyc("r.exec",  0, 0, 6'h00, 4'd6, V_EXEC);
        cyc("r.wb",    0, 1, 6'h00, 4'd7, V_ALUWB);

        cyc("lw.fetch", 0, 1, 6'h23, 4'd0, V_FETCH);
        cyc("lw.dec",   0, 1, 6'h23, 4'd1, V_DEC);
        cyc("lw.adr",   0, 1, 6'h23, 4'd2, V_MADR);
        cyc("lw.rd0",   0, 0, 6'h23, 4'd3, V_MRD);
        cyc("lw.rd1",   0, 0, 6'h23, 4'd3, V_MRD);
        cyc("lw.rd2",   0, 1, 6'h23, 4'd3, V_MRD);
        cyc("lw.wb",    0, 1, 6'h23, 4'd4, V_MWB);

        cyc("beq.st0",  0, 0, 6'h04, 4'd0, V_FSTALL);
        cyc("beq.st1",  0, 0, 6'h04, 4'd0, V_FSTALL);
        cyc("beq.st2",  0, 0, 6'h04, 4'd0, V_FSTALL);
        cyc("beq.fetch",0, 1, 6'h04, 4'd0, V_FETCH);
        cyc("beq.dec",  0, 1, 6'h04, 4'd1, V_DEC);
        cyc("beq.br",   0, 1, 6'h04, 4'd8, V_BR);

        cyc("ill.fetch",0, 1, 6'h3f, 4'd0, V_FETCH);
        cyc("ill.dec",  0, 1, 6'h3f, 4'd1, V_DECILL);

        cyc("swr.fetch",0, 1, 6'h2b, 4'd0, V_FETCH);
        cyc("swr.dec",  0, 1, 6'h2b, 4'd1, V_DEC);
        cyc("swr.adr",  0, 1, 6'h2b, 4'd2, V_MADR);
        cyc("swr.wr0",  0, 0, 6'h2b, 4'd5, V_MWR);
        cyc("swr.rst",  1, 0, 6'h2b, 4'd0, 18'h0);
        cyc("swr.after",0, 0, 6'h2b, 4'd0, V_FSTALL);

        cyc("sw.fetch", 0, 1, 6'h2b, 4'd0, V_FETCH);
        cyc("sw.dec",   0, 1, 6'h2b, 4'd1, V_DEC);
        cyc("sw.adr",   0, 1, 6'h2b, 4'd2, V_MADR);
        cyc("sw.wr",    0, 1, 6'h2b, 4'd5, V_MWRD);

        cyc("j.fetch",  0, 1, 6'h02, 4'd0, V_FETCH);
        cyc("j.dec",    0, 1, 6'h02, 4'd1, V_DEC);
        cyc("j.jmp",    0, 1, 6'h02, 4'd9, V_JMP);

        cyc("ai.fetch", 0, 1, 6'h08, 4'd0, V_FETCH);
`ifdef MC_ADDI_EN
        cyc("ai.dec",   0, 1, 6'h08, 4'd1, V_DEC);
        cyc("ai.ex",    0, 1, 6'h08, 4'd10, V_AIEX);
        cyc("ai.wb",    0, 1, 6'h08, 4'd11, V_AIWB);
`else
        cyc("ai.dec",   0, 1, 6'h08, 4'd1, V_DECILL);
`endif
        cyc("end.fetch",0, 0, 6'h00, 4'd0, V_FSTALL);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
